// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, descriptor kinds, ALU op codes and loader error codes.
// Used by both the control decoder and the program-load encoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    KIND_R       = 3'd0,
    KIND_OPIMM   = 3'd1,
    KIND_LOAD    = 3'd2,
    KIND_STORE   = 3'd3,
    KIND_BRANCH  = 3'd4,
    KIND_JAL     = 3'd5,
    KIND_JALR    = 3'd6,
    KIND_ILLEGAL = 3'd7
  } kind_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_IMM     = 2'b10;
  localparam logic [1:0] ERR_OVF     = 2'b11;

  typedef struct packed {
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ok;
  } alu_fields_t;

  // Maps an ALU op onto its funct7/funct3 pair; ok is low for unknown ops.
  function automatic alu_fields_t alu_fields(input logic [3:0] op);
    alu_fields_t r;
    r.f7 = 7'h00;
    r.f3 = 3'b000;
    r.ok = 1'b1;
    case (op)
      ALU_ADD:  r.f3 = 3'b000;
      ALU_SUB:  r.f7 = 7'h20;
      ALU_AND:  r.f3 = 3'b111;
      ALU_OR:   r.f3 = 3'b110;
      ALU_SLT:  r.f3 = 3'b010;
      ALU_SLTU: r.f3 = 3'b011;
      default:  r.ok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: one instruction descriptor in, RV32I word plus legality flags out.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [3:0]  aluop,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        imm_bad
);

  alu_fields_t alu_s;
  logic        i_ok_s;
  logic        b_ok_s;
  logic        j_ok_s;

  assign alu_s = alu_fields(aluop);

  // An immediate fits when every bit above the field's sign bit copies it.
  assign i_ok_s = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok_s = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok_s = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

  // Field packing per instruction format.
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    imm_bad = 1'b0;
    case (kind_t'(kind))
      KIND_R: begin
        word    = {alu_s.f7, rs2, rs1, alu_s.f3, rd, OP_R};
        illegal = ~alu_s.ok;
      end
      KIND_OPIMM: begin
        word    = {imm[11:0], rs1, alu_s.f3, rd, OP_IMM};
        illegal = ~alu_s.ok | (aluop == ALU_SUB);
        imm_bad = ~i_ok_s;
      end
      KIND_LOAD: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        imm_bad = ~i_ok_s;
      end
      KIND_STORE: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        imm_bad = ~i_ok_s;
      end
      KIND_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        imm_bad = ~b_ok_s;
      end
      KIND_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        imm_bad = ~j_ok_s;
      end
      KIND_JALR: begin
        word    = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        imm_bad = ~i_ok_s;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Boot/test program loader: encodes descriptors into RV32I words and writes them to
// consecutive imem word addresses through a single output stage.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [3:0]        in_aluop,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP  = {ADDR_W{1'b1}};

  state_t            state_r;
  logic [ADDR_W-1:0] aptr_r;
  logic              ovf_r;
  logic [ADDR_W:0]   count_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [1:0]        err_code_r;

  logic              accept_s;
  logic [31:0]       word_s;
  logic              illegal_s;
  logic              imm_bad_s;
  logic [1:0]        code_s;

  instr_pack u_pack (
    .kind    (in_kind),
    .aluop   (in_aluop),
    .funct3  (in_funct3),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (word_s),
    .illegal (illegal_s),
    .imm_bad (imm_bad_s)
  );

  assign in_ready = (state_r == S_RUN) && (!mem_we_r || mem_ready);
  assign accept_s = in_valid && in_ready;

  // Error classification of the presented descriptor; encoding faults outrank overflow.
  always_comb begin
    if (illegal_s) begin
      code_s = ERR_ILLEGAL;
    end else if (imm_bad_s) begin
      code_s = ERR_IMM;
    end else if (ovf_r) begin
      code_s = ERR_OVF;
    end else begin
      code_s = ERR_NONE;
    end
  end

  // Session FSM, output stage, write pointer, counters and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      aptr_r      <= BASE;
      ovf_r       <= 1'b0;
      count_r     <= '0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= BASE;
      mem_wdata_r <= 32'h0000_0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= ERR_NONE;
    end else if (start) begin
      state_r    <= S_RUN;
      aptr_r     <= BASE;
      ovf_r      <= 1'b0;
      count_r    <= '0;
      mem_we_r   <= 1'b0;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
    end else begin
      done_r <= 1'b0;
      if (mem_we_r && mem_ready) begin
        mem_we_r <= 1'b0;
        count_r  <= count_r + (ADDR_W+1)'(1'b1);
      end
      // A new word may be staged in the same cycle the previous one retires.
      if (accept_s) begin
        if (code_s == ERR_NONE) begin
          mem_we_r    <= 1'b1;
          mem_addr_r  <= aptr_r;
          mem_wdata_r <= word_s;
          aptr_r      <= aptr_r + ADDR_W'(1'b1);
          if (aptr_r == TOP) begin
            ovf_r <= 1'b1;
          end
        end else if (!err_r) begin
          err_r      <= 1'b1;
          err_code_r <= code_s;
        end
      end
      case (state_r)
        S_RUN: begin
          if (accept_s && in_last) begin
            state_r <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!mem_we_r) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign err_code  = err_code_r;
  assign count     = count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a default-size loader and a 4-word loader share one stimulus stream,
// each checked against a behavioural encoder/allocation model.
module tb_instr_encoder;

  typedef struct {
    logic [2:0]  kind;
    logic [3:0]  aluop;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
  } desc_t;

  logic        clk, rst_n, start, in_valid, in_last;
  logic [2:0]  in_kind, in_funct3;
  logic [3:0]  in_aluop;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        rdy_dir, rnd_en, rnd_r, mem_ready;

  logic        in_ready0, mem_we0, busy0, done0, err0;
  logic [9:0]  mem_addr0;
  logic [31:0] mem_wdata0;
  logic [1:0]  err_code0;
  logic [10:0] count0;
  logic        in_ready1, mem_we1, busy1, done1, err1;
  logic [1:0]  mem_addr1;
  logic [31:0] mem_wdata1;
  logic [1:0]  err_code1;
  logic [2:0]  count1;

  logic [1:0]  done_v, busy_v;
  assign done_v = {done1, done0};
  assign busy_v = {busy1, busy0};
  assign mem_ready = rnd_en ? rnd_r : rdy_dir;

  int          n_cmp, n_bad;
  int          alloc[2], cap[2], ecode_m[2], cnt_m[2];
  logic [63:0] q0[$], q1[$];
  logic [3:0]  legal_ops [6] = '{4'd0, 4'd1, 4'd9, 4'd8, 4'd3, 4'd4};
  int          bnd [12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                            1048574, 1048576, -1048576, -1048578};

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .in_kind(in_kind), .in_aluop(in_aluop), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_ready(mem_ready),
    .busy(busy0), .done(done0), .err(err0), .err_code(err_code0), .count(count0));

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .in_kind(in_kind), .in_aluop(in_aluop), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_ready(mem_ready),
    .busy(busy1), .done(done1), .err(err1), .err_code(err_code1), .count(count1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Random imem back-pressure, stable for a whole cycle.
  always @(posedge clk) rnd_r <= ($urandom_range(0, 3) != 0);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Encoding written directly from the RV32I field layout; returns 0 ok, 1 illegal, 2 imm range.
  function automatic int ref_encode(input desc_t d, output logic [31:0] w);
    logic [31:0] u;
    int s, f7, f3;
    bit aok;
    u = d.imm;
    s = $signed(d.imm);
    f7 = 0; f3 = 0; aok = 1'b1;
    case (d.aluop)
      4'd0: f3 = 0;
      4'd1: f7 = 32;
      4'd9: f3 = 7;
      4'd8: f3 = 6;
      4'd3: f3 = 2;
      4'd4: f3 = 3;
      default: aok = 1'b0;
    endcase
    w = 32'h0;
    case (d.kind)
      3'd0: begin
        w = (f7 << 25) | (32'(d.rs2) << 20) | (32'(d.rs1) << 15) | (f3 << 12) | (32'(d.rd) << 7) | 32'h33;
        return aok ? 0 : 1;
      end
      3'd1: begin
        w = ((u & 32'hfff) << 20) | (32'(d.rs1) << 15) | (f3 << 12) | (32'(d.rd) << 7) | 32'h13;
        if (!aok || d.aluop == 4'd1) return 1;
        return (s >= -2048 && s <= 2047) ? 0 : 2;
      end
      3'd2: begin
        w = ((u & 32'hfff) << 20) | (32'(d.rs1) << 15) | (32'(d.f3) << 12) | (32'(d.rd) << 7) | 32'h03;
        return (s >= -2048 && s <= 2047) ? 0 : 2;
      end
      3'd3: begin
        w = (((u >> 5) & 32'h7f) << 25) | (32'(d.rs2) << 20) | (32'(d.rs1) << 15) | (32'(d.f3) << 12)
          | ((u & 32'h1f) << 7) | 32'h23;
        return (s >= -2048 && s <= 2047) ? 0 : 2;
      end
      3'd4: begin
        w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3f) << 25) | (32'(d.rs2) << 20)
          | (32'(d.rs1) << 15) | (32'(d.f3) << 12) | (((u >> 1) & 32'hf) << 8)
          | (((u >> 11) & 32'h1) << 7) | 32'h63;
        return (s >= -4096 && s <= 4095 && s % 2 == 0) ? 0 : 2;
      end
      3'd5: begin
        w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3ff) << 21) | (((u >> 11) & 32'h1) << 20)
          | (((u >> 12) & 32'hff) << 12) | (32'(d.rd) << 7) | 32'h6f;
        return (s >= -1048576 && s <= 1048575 && s % 2 == 0) ? 0 : 2;
      end
      3'd6: begin
        w = ((u & 32'hfff) << 20) | (32'(d.rs1) << 15) | (32'(d.rd) << 7) | 32'h67;
        return (s >= -2048 && s <= 2047) ? 0 : 2;
      end
      default: return 1;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      alloc[i] = 0; ecode_m[i] = 0; cnt_m[i] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_accept(input desc_t d);
    logic [31:0] w;
    int c, ci;
    c = ref_encode(d, w);
    for (int i = 0; i < 2; i++) begin
      ci = c;
      if (ci == 0) begin
        if (alloc[i] >= cap[i]) ci = 3;
        else begin
          if (i == 0) q0.push_back({32'(alloc[i]), w});
          else        q1.push_back({32'(alloc[i]), w});
          alloc[i]++;
        end
      end
      if (ci != 0 && ecode_m[i] == 0) ecode_m[i] = ci;
    end
  endtask

  function automatic desc_t mk(input int kind, input int aluop, input int f3, input int rd,
                               input int rs1, input int rs2, input int imm, input bit last);
    desc_t d;
    d.kind = 3'(kind); d.aluop = 4'(aluop); d.f3 = 3'(f3); d.rd = 5'(rd);
    d.rs1 = 5'(rs1); d.rs2 = 5'(rs2); d.imm = 32'(imm); d.last = last;
    return d;
  endfunction

  task automatic drive(input desc_t d);
    @(posedge clk); #1;
    in_valid = 1'b1; in_kind = d.kind; in_aluop = d.aluop; in_funct3 = d.f3;
    in_rd = d.rd; in_rs1 = d.rs1; in_rs2 = d.rs2; in_imm = d.imm; in_last = d.last;
  endtask

  task automatic wait_accept(input desc_t d);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready0 === 1'b1) ok = 1'b1;
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    if (ok) model_accept(d);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send(input desc_t d);
    drive(d);
    wait_accept(d);
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    model_clear();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int idx);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (done_v[idx] === 1'b1) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    chk("done_pulse", 64'(done_v[idx]), 64'd0);
    chk("busy_fall", 64'(busy_v[idx]), 64'd0);
    chk("count_done", idx == 0 ? 64'(count0) : 64'(count1), 64'(cnt_m[idx]));
  endtask

  initial begin
    desc_t d;
    n_cmp = 0; n_bad = 0;
    cap[0] = 1024; cap[1] = 4;
    model_clear();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_kind = 3'd0; in_aluop = 4'd0; in_funct3 = 3'd0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    rdy_dir = 1'b1; rnd_en = 1'b0;

    // Write monitor: every completed imem write must match the model's next word.
    fork
      forever begin
        @(negedge clk);
        if (mem_we0 === 1'b1 && mem_ready === 1'b1) begin
          chk("w0_expected", 64'(q0.size() > 0), 64'd1);
          if (q0.size() > 0) begin
            chk("w0_addr_data", {32'(mem_addr0), mem_wdata0}, q0.pop_front());
            cnt_m[0]++;
          end
        end
        if (mem_we1 === 1'b1 && mem_ready === 1'b1) begin
          chk("w1_expected", 64'(q1.size() > 0), 64'd1);
          if (q1.size() > 0) begin
            chk("w1_addr_data", {32'(mem_addr1), mem_wdata1}, q1.pop_front());
            cnt_m[1]++;
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready0), 64'd0);
    chk("rst_mem_we", 64'(mem_we0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_err_code", 64'(err_code0), 64'd0);
    chk("rst_count", 64'(count0), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr0), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata0), 64'd0);
    chk("rst_count1", 64'(count1), 64'd0);

    // Session 1: spec example words, one-cycle latency.
    do_start();
    @(negedge clk);
    chk("run_busy", 64'(busy0), 64'd1);
    chk("run_in_ready", 64'(in_ready0), 64'd1);
    send(mk(0, 0, 0, 3, 1, 2, 0, 1'b0));
    @(negedge clk);
    chk("radd_we", 64'(mem_we0), 64'd1);
    chk("radd_word", 64'(mem_wdata0), 64'h0020_81B3);
    chk("radd_addr", 64'(mem_addr0), 64'd0);
    send(mk(1, 0, 0, 1, 0, 0, 5, 1'b0));
    @(negedge clk);
    chk("opimm_word", 64'(mem_wdata0), 64'h0050_0093);
    chk("opimm_addr", 64'(mem_addr0), 64'd1);
    send(mk(3, 0, 2, 0, 0, 2, 8, 1'b0));
    @(negedge clk);
    chk("store_word", 64'(mem_wdata0), 64'h0020_2423);
    send(mk(5, 0, 0, 1, 0, 0, 8, 1'b1));
    @(negedge clk);
    chk("jal_word", 64'(mem_wdata0), 64'h0080_00EF);
    chk("jal_addr", 64'(mem_addr0), 64'd3);
    wait_done(0);
    chk("s1_count4", 64'(count0), 64'd4);

    // Session 2: imem stall holds the stage and blocks the next descriptor.
    do_start();
    rdy_dir = 1'b0;
    send(mk(0, 1, 0, 3, 1, 2, 0, 1'b0));
    d = mk(1, 9, 0, 5, 3, 0, -1, 1'b1);
    drive(d);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready0), 64'd0);
      chk("stall_we", 64'(mem_we0), 64'd1);
      chk("stall_addr", 64'(mem_addr0), 64'd0);
      chk("stall_word", 64'(mem_wdata0), 64'h4020_81B3);
    end
    @(posedge clk); #1;
    rdy_dir = 1'b1;
    wait_accept(d);
    @(negedge clk);
    chk("after_stall_addr", 64'(mem_addr0), 64'd1);
    chk("after_stall_word", 64'(mem_wdata0), 64'hFFF1_F293);
    wait_done(0);
    chk("s2_count2", 64'(count0), 64'd2);

    // Session 3: immediate out of range, then illegal op keeps the first code.
    do_start();
    send(mk(1, 0, 0, 1, 0, 0, 2048, 1'b0));
    @(negedge clk);
    chk("imm_err", 64'(err0), 64'd1);
    chk("imm_err_code", 64'(err_code0), 64'd2);
    chk("imm_no_we", 64'(mem_we0), 64'd0);
    chk("imm_count", 64'(count0), 64'd0);
    send(mk(1, 1, 0, 1, 0, 0, 1, 1'b0));
    @(negedge clk);
    chk("sticky_code", 64'(err_code0), 64'd2);
    send(mk(0, 9, 0, 7, 4, 5, 0, 1'b1));
    @(negedge clk);
    chk("rand_word", 64'(mem_wdata0), 64'h0052_73B3);
    wait_done(0);
    chk("s3_err_kept", 64'(err0), 64'd1);

    // Session 4: randomized descriptors with random back-pressure.
    do_start();
    rnd_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      int r;
      d.kind = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 7);
      d.aluop = (r < 6) ? legal_ops[r] : 4'($urandom);
      d.f3 = 3'($urandom); d.rd = 5'($urandom); d.rs1 = 5'($urandom); d.rs2 = 5'($urandom);
      case ($urandom_range(0, 4))
        0: d.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: d.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: d.imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        3: d.imm = $urandom;
        default: d.imm = 32'(bnd[$urandom_range(0, 11)]);
      endcase
      d.last = (k == 149);
      send(d);
    end
    wait_done(0);
    rnd_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("rnd_err_code0", 64'(err_code0), 64'(ecode_m[0]));
    chk("rnd_err0", 64'(err0), 64'(ecode_m[0] != 0));
    chk("rnd_err_code1", 64'(err_code1), 64'(ecode_m[1]));
    chk("rnd_count1", 64'(count1), 64'(cnt_m[1]));

    // Session 5: 4-word memory overflows on the fifth descriptor.
    do_start();
    for (int k = 1; k <= 5; k++) send(mk(1, 0, 0, 1, 0, 0, k, k == 5));
    wait_done(1);
    chk("ovf_count", 64'(count1), 64'd4);
    chk("ovf_code", 64'(err_code1), 64'd3);
    chk("ovf_last_addr", 64'(mem_addr1), 64'd3);

    // Session 6: restart while flushing discards the staged word.
    do_start();
    rdy_dir = 1'b0;
    send(mk(1, 0, 0, 2, 0, 0, 9, 1'b1));
    @(negedge clk);
    chk("flush_staged", 64'(mem_we1), 64'd1);
    do_start();
    @(negedge clk);
    chk("restart_we", 64'(mem_we1), 64'd0);
    chk("restart_count", 64'(count1), 64'd0);
    chk("restart_busy", 64'(busy1), 64'd1);
    chk("restart_err", 64'(err1), 64'd0);
    rdy_dir = 1'b1;
    send(mk(1, 0, 0, 2, 0, 0, 10, 1'b1));
    @(negedge clk);
    chk("restart_addr", 64'(mem_addr1), 64'd0);
    chk("restart_word", 64'(mem_wdata1), 64'h00A0_0113);
    wait_done(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
